// File: rtl/trig_arb_pkg.sv
// Shared definitions for the trigger arbiter: state encoding, counter width
// and the default parameter values.
package trig_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_WAIT = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam int CNT_W           = 4;
   localparam int DEF_N_REQ       = 4;
   localparam int DEF_HOLD_CYC    = 3;
   localparam int DEF_TIMEOUT_CYC = 8;
   localparam int DEF_GAP_CYC     = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester above last_winner
// wins, otherwise the lowest-numbered requester wins.
module rr_pick
   import trig_arb_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_winner,
   output logic [N_REQ-1:0] winner
);

   logic found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (i > int'(last_winner))) begin
            winner[i] = 1'b1;
            found     = 1'b1;
         end
      end
      // Wrap-around pass: nobody above last_winner is asking.
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i]) begin
            winner[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/trigger_arbiter.sv
// Arbitrates a single shared trigger generator between N_REQ requesters:
// hold enable, wait for the returned trigger (or time out), then a gap.
module trigger_arbiter
   import trig_arb_pkg::*;
#(
   parameter int N_REQ       = DEF_N_REQ,
   parameter int HOLD_CYC    = DEF_HOLD_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int GAP_CYC     = DEF_GAP_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             trigger_in,
   output logic             ena_out,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] err,
   output logic             busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] TOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]   last_winner, last_winner_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt, winner_idx;
   logic               trig_seen, trig_seen_nxt;
   logic               ena_nxt, busy_nxt, finish;
   logic [N_REQ-1:0]   winner, grant_nxt, done_nxt, err_nxt;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .req         (req),
      .last_winner (last_winner),
      .winner      (winner)
   );

   always_comb begin
      winner_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner[i]) winner_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         last_winner <= IDX_W'(N_REQ - 1);
         owner       <= '0;
         trig_seen   <= 1'b0;
         ena_out     <= 1'b0;
         grant       <= '0;
         done        <= '0;
         err         <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         last_winner <= last_winner_nxt;
         owner       <= owner_nxt;
         trig_seen   <= trig_seen_nxt;
         ena_out     <= ena_nxt;
         grant       <= grant_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
         busy        <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      last_winner_nxt = last_winner;
      owner_nxt       = owner;
      trig_seen_nxt   = trig_seen;
      grant_nxt       = grant;
      done_nxt        = '0;
      err_nxt         = '0;
      finish          = 1'b0;

      case (state)
         S_IDLE: begin
            if (|req) begin
               state_nxt     = S_HOLD;
               cnt_nxt       = HOLD_LOAD;
               grant_nxt     = winner;
               owner_nxt     = winner_idx;
               trig_seen_nxt = 1'b0;
            end
         end
         S_HOLD: begin
            if (trigger_in) trig_seen_nxt = 1'b1;
            if (cnt == '0) begin
               state_nxt = S_WAIT;
               cnt_nxt   = TOUT_LOAD;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_WAIT: begin
            // A trigger caught during HOLD ends WAIT on its first cycle.
            if (trig_seen || trigger_in) begin
               done_nxt = grant;
               finish   = 1'b1;
            end else if (cnt == '0) begin
               err_nxt = grant;
               finish  = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt == '0) begin
               state_nxt       = S_IDLE;
               cnt_nxt         = '0;
               grant_nxt       = '0;
               last_winner_nxt = owner;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (finish) begin
         if (GAP_CYC == 0) begin
            state_nxt       = S_IDLE;
            cnt_nxt         = '0;
            grant_nxt       = '0;
            last_winner_nxt = owner;
         end else begin
            state_nxt = S_GAP;
            cnt_nxt   = GAP_LOAD;
         end
      end

      ena_nxt  = (state_nxt == S_HOLD);
      busy_nxt = (state_nxt != S_IDLE);
   end

endmodule

// File: doc/trigger_arbiter.md
TRIGGER_ARBITER -- requirements
Module: trigger_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the trigger generator.
REQ-002 Parameter HOLD_CYC, default 3: cycles ena_out is held high per grant; legal range 1..15.
REQ-003 Parameter TIMEOUT_CYC, default 8: cycles to wait for trigger_in after ena_out falls; legal range 1..15.
REQ-004 Parameter GAP_CYC, default 1: idle cycles after each grant before the next arbitration; legal range 0..15.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, N_REQ: level requests; bit i high means requester i wants one trigger cycle.
REQ-008 Port trigger_in, input, 1: trigger pulse returned by the shared trigger generator.
REQ-009 Port ena_out, output, 1: enable driven to the shared trigger generator.
REQ-010 Port grant, output, N_REQ: one-hot owner of the current cycle; all zero when idle.
REQ-011 Port done, output, N_REQ: one-cycle pulse to the owner when trigger_in is seen.
REQ-012 Port err, output, N_REQ: one-cycle pulse to the owner on timeout.
REQ-013 Port busy, output, 1: high in every state except IDLE.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, HOLD, WAIT, GAP.
REQ-015 In IDLE with any req bit high, the block SHALL pick a winner by round-robin starting at last_winner+1 (mod N_REQ), then enter HOLD on the next edge with grant set.
REQ-016 In HOLD, ena_out SHALL be high for exactly HOLD_CYC cycles, then the block SHALL enter WAIT.
REQ-017 In WAIT, trigger_in high SHALL pulse done[owner] in the following cycle and move to GAP.
REQ-018 In WAIT, if trigger_in is not seen within TIMEOUT_CYC cycles, the block SHALL pulse err[owner] and move to GAP.
REQ-019 trigger_in high during HOLD SHALL be recorded and SHALL end WAIT on its first cycle with done, not err.
REQ-020 trigger_in in IDLE or GAP SHALL be ignored.
REQ-021 GAP SHALL last GAP_CYC cycles; GAP_CYC=0 means WAIT goes straight to IDLE. The block SHALL then return to IDLE, clear grant, and update last_winner to the owner.
REQ-022 grant SHALL stay constant from HOLD entry to GAP exit. Deasserting req[owner] mid-grant SHALL NOT abort the sequence.
REQ-023 A requester holding req high SHALL get at most one grant per arbitration round while other requesters are pending; the fairness bound is N_REQ grants.
REQ-024 One shared cycle counter SHALL be used, CNT_W=4 bits, reloaded on every state entry. It SHALL never wrap.
REQ-025 done and err SHALL be mutually exclusive and at most one bit of each SHALL be high.

Reset
REQ-026 While rst is high: state=IDLE, ena_out=0, grant=0, done=0, err=0, busy=0, counter=0, last_winner=N_REQ-1 (so requester 0 wins first).
REQ-027 rst asserted mid-HOLD or mid-WAIT SHALL drop ena_out and grant on the next edge with no done or err pulse.

Structure
REQ-028 A shared package trig_arb_pkg SHALL hold the state encoding, CNT_W, and the default parameter constants.
REQ-029 The round-robin priority picker SHALL be a sub-module rr_pick (inputs req and last_winner; output one-hot winner). It SHALL be purely combinational.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Single request: req=0001 and trigger_in pulsed 2 cycles after ena_out falls -> grant=0001, ena_out high 3 cycles, done=0001 for 1 cycle, busy low after GAP.
REQ-032 Timeout: req=0010 and trigger_in never asserted -> err=0010 exactly 8 cycles after ena_out falls, done stays 0.
REQ-033 Fairness: req=1111 held for 40 cycles, trigger returned each time -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-034 Early trigger: trigger_in high during the 2nd HOLD cycle -> WAIT lasts 1 cycle and done pulses; no err.
REQ-035 Reset mid-operation: rst high for 2 cycles during WAIT -> ena_out=0, grant=0, no done/err; after release with req=1000 the first grant is 1000.
REQ-036 Request drop: req[owner] deasserted during HOLD -> ena_out still held 3 cycles and the sequence completes normally.
